// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port of the KGP-RISC PC sequencer (req/ack handshake).
interface pc_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_sequencer.sv
// KGP-RISC program counter and fetch sequencer: fetch, hold for execute, commit next PC.
// Optional macro PC_TRAP_MISALIGN_EN traps misaligned branch targets into HALTED.
//
// state   | meaning
// IDLE    | one cycle after reset release
// FETCH   | imem_req high at pc, waiting for imem_ack
// ISSUE   | instr held valid until exec_done
// HALTED  | stopped until reset
module pc_sequencer #(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   pc_sequencer_if.master    imem,
   input  logic              exec_done_i,
   input  logic              branch_taken_i,
   input  logic              target_is_reg_i,
   input  logic [ADDR_W-1:0] abs_target_i,
   input  logic [ADDR_W-1:0] reg_target_i,
   input  logic              link_en_i,
   input  logic              halt_req_i,
   output logic [31:0]       instr_o,
   output logic              instr_valid_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] link_pc_o,
   output logic              halted_o,
   output logic              misalign_err_o
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALTED} state_t;

   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] link_pc_q, link_pc_d;
   logic [31:0]       instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              halted_q, halted_d;
   logic              misalign_q, misalign_d;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] target_sel;

   assign pc_plus4   = pc_q + PC_STEP;
   assign target_sel = target_is_reg_i ? reg_target_i : abs_target_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         link_pc_q     <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         link_pc_q     <= link_pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
         misalign_q    <= misalign_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      link_pc_d     = link_pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      misalign_d    = misalign_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (imem.imem_ack) begin
               instr_d       = imem.imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (exec_done_i) begin
               if (link_en_i) link_pc_d = pc_plus4;
               instr_valid_d = 1'b0;
               state_d       = S_FETCH;
               if (halt_req_i) begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end else if (branch_taken_i) begin
`ifdef PC_TRAP_MISALIGN_EN
                  if (target_sel[1:0] != 2'b00) begin
                     state_d    = S_HALTED;
                     halted_d   = 1'b1;
                     misalign_d = 1'b1;
                  end else begin
                     pc_d = target_sel;
                  end
`else
                  pc_d = target_sel & ALIGN_MASK;
`endif
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         S_HALTED: begin
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem.imem_req  = (state_q == S_FETCH);
   assign imem.imem_addr = pc_q;
   assign instr_o        = instr_q;
   assign instr_valid_o  = instr_valid_q;
   assign pc_o           = pc_q;
   assign link_pc_o      = link_pc_q;
   assign halted_o       = halted_q;
`ifdef PC_TRAP_MISALIGN_EN
   assign misalign_err_o = misalign_q;
`else
   // Alignment is forced on load, so no error can ever be raised.
   assign misalign_err_o = 1'b0 & misalign_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the sequencer.
module tb_pc_sequencer;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        exec_done, branch_taken, target_is_reg, link_en, halt_req;
   logic [31:0] abs_target, reg_target;
   logic [31:0] instr, pc, link_pc;
   logic        instr_valid, halted, misalign_err;

   pc_sequencer_if #(.ADDR_W(32)) imem_bus ();

   pc_sequencer #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .imem           (imem_bus.master),
      .exec_done_i    (exec_done),
      .branch_taken_i (branch_taken),
      .target_is_reg_i(target_is_reg),
      .abs_target_i   (abs_target),
      .reg_target_i   (reg_target),
      .link_en_i      (link_en),
      .halt_req_i     (halt_req),
      .instr_o        (instr),
      .instr_valid_o  (instr_valid),
      .pc_o           (pc),
      .link_pc_o      (link_pc),
      .halted_o       (halted),
      .misalign_err_o (misalign_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: what the sequencer is doing and the architectural values.
   typedef enum {BOOTING, AWAIT_FETCH, HOLD_INSTR, STOPPED} activity_t;
   activity_t   m_act;
   logic [31:0] m_pc, m_link, m_instr, tgt;
   logic        m_valid, m_halted, m_mis;
   bit          model_ok = 0;

   always @(posedge clk) begin
      if (rst === 1'b0) begin
         model_ok = 1;
         m_act = BOOTING; m_pc = RST_PC; m_link = 0; m_instr = 0;
         m_valid = 0; m_halted = 0; m_mis = 0;
      end else if (model_ok) begin
         if (m_act == BOOTING) m_act = AWAIT_FETCH;
         else if (m_act == AWAIT_FETCH && imem_bus.imem_ack) begin
            m_instr = imem_bus.imem_rdata; m_valid = 1; m_act = HOLD_INSTR;
         end else if (m_act == HOLD_INSTR && exec_done) begin
            if (link_en) m_link = m_pc + 32'd4;
            m_valid = 0;
            m_act = AWAIT_FETCH;
            if (halt_req) begin
               m_act = STOPPED; m_halted = 1;
            end else if (branch_taken) begin
               tgt = target_is_reg ? reg_target : abs_target;
`ifdef PC_TRAP_MISALIGN_EN
               if (tgt % 4 != 0) begin m_act = STOPPED; m_halted = 1; m_mis = 1; end
               else m_pc = tgt;
`else
               m_pc = tgt - (tgt % 4);
`endif
            end else m_pc = m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("cyc_imem_req", {31'd0, imem_bus.imem_req}, {31'd0, m_act == AWAIT_FETCH});
         check("cyc_imem_addr", imem_bus.imem_addr, m_pc);
         check("cyc_pc", pc, m_pc);
         check("cyc_instr", instr, m_instr);
         check("cyc_instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
         check("cyc_link_pc", link_pc, m_link);
         check("cyc_halted", {31'd0, halted}, {31'd0, m_halted});
         check("cyc_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
      exec_done = 0; branch_taken = 0; target_is_reg = 0;
      abs_target = 0; reg_target = 0; link_en = 0; halt_req = 0;
   endtask

   task automatic fetch(input int waits, input logic [31:0] data);
      int n = 0;
      while (imem_bus.imem_req !== 1'b1 && n < 40) begin tick(); n++; end
      check("fetch_req_timeout", {31'd0, imem_bus.imem_req}, 32'd1);
      repeat (waits) tick();
      imem_bus.imem_ack = 1; imem_bus.imem_rdata = data;
      tick();
      clear_inputs();
   endtask

   task automatic execute(input logic br, input logic sel_reg, input logic [31:0] abs_t,
                          input logic [31:0] reg_t, input logic lnk, input logic hlt);
      int n = 0;
      while (instr_valid !== 1'b1 && n < 40) begin tick(); n++; end
      check("exec_valid_timeout", {31'd0, instr_valid}, 32'd1);
      exec_done = 1; branch_taken = br; target_is_reg = sel_reg;
      abs_target = abs_t; reg_target = reg_t; link_en = lnk; halt_req = hlt;
      tick();
      clear_inputs();
   endtask

   initial begin
      int stuck;
      rst = 0;
      clear_inputs();
      tick(); tick();
      check("rst_pc", pc, 32'h100);
      check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_link", link_pc, 32'd0);
      check("rst_instr", instr, 32'd0);

      rst = 1;
      tick();
      check("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check("first_addr", imem_bus.imem_addr, 32'h100);
      fetch(3, 32'hDEADBEEF);
      check("first_instr", instr, 32'hDEADBEEF);
      check("first_valid", {31'd0, instr_valid}, 32'd1);

      execute(0, 0, 0, 0, 0, 0);
      check("seq_pc1", pc, 32'h104);
      check("seq_addr1", imem_bus.imem_addr, 32'h104);
      fetch(0, 32'h1111_0001);
      execute(0, 0, 0, 0, 0, 0);
      fetch(1, 32'h1111_0002);
      check("seq_pc2", pc, 32'h108);

      execute(1, 0, 32'h40, 32'h999, 1, 0);
      check("br_pc", pc, 32'h40);
      check("br_link", link_pc, 32'h10C);
      check("br_addr", imem_bus.imem_addr, 32'h40);

      fetch(0, 32'h2222_0000);
      execute(1, 0, 32'h80, 0, 0, 1);
      check("halt_pc", pc, 32'h40);
      check("halt_flag", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         imem_bus.imem_ack = 1; exec_done = 1;
         tick();
      end
      clear_inputs();
      check("halt_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
      rst = 0; tick(); rst = 1;
      check("halt_rst_pc", pc, 32'h100);
      check("halt_rst_flag", {31'd0, halted}, 32'd0);

      tick();
      fetch(0, 32'h3333_0000);
      execute(1, 0, 32'hFFFF_FFFC, 0, 0, 0);
      check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      fetch(2, 32'h3333_0001);
      execute(0, 0, 0, 0, 1, 0);
      check("wrap_pc", pc, 32'h0);
      check("wrap_link", link_pc, 32'h0);
      fetch(0, 32'h3333_0002);
      execute(1, 1, 32'h4, 32'h203, 0, 0);
`ifdef PC_TRAP_MISALIGN_EN
      check("mis_halted", {31'd0, halted}, 32'd1);
      check("mis_err", {31'd0, misalign_err}, 32'd1);
      check("mis_pc", pc, 32'h0);
`else
      check("align_pc", pc, 32'h200);
      check("align_err", {31'd0, misalign_err}, 32'd0);
`endif

      rst = 0; tick(); rst = 1;
      tick(); tick();
      check("midfetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
      rst = 0; tick(); rst = 1;
      check("midfetch_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("midfetch_rst_valid", {31'd0, instr_valid}, 32'd0);
      tick();
      check("refetch_addr", imem_bus.imem_addr, 32'h100);
      check("refetch_req", {31'd0, imem_bus.imem_req}, 32'd1);

      stuck = 0;
      for (int i = 0; i < 4000; i++) begin
         imem_bus.imem_ack   = ($urandom_range(0, 2) == 0);
         imem_bus.imem_rdata = $urandom;
         exec_done     = ($urandom_range(0, 2) == 0);
         branch_taken  = $urandom_range(0, 1);
         target_is_reg = $urandom_range(0, 1);
         abs_target    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         reg_target    = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
         link_en       = $urandom_range(0, 1);
         halt_req      = ($urandom_range(0, 19) == 0);
         stuck         = halted ? stuck + 1 : 0;
         rst           = !(($urandom_range(0, 199) == 0) || stuck > 6);
         tick();
      end
      rst = 1;
      clear_inputs();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
